// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter and byte sequencer sharing one UART transmitter
// among N_REQ byte-stream requesters. A grant is held for a packet, which ends on the
// last byte, when the owner drops its request, or after MAX_BURST bytes.
//
// Ports:
//   clk       clock
//   reset     asynchronous reset, active-low
//   req       per-requester byte valid / request
//   req_data  per-requester byte, requester i on bits [8i+7:8i]
//   req_last  byte on req_data[i] is the last of its packet
//   ack       one-cycle pulse: byte of requester i committed to the transmitter
//   grant     one-hot current owner, zero when idle
//   busy      arbiter owns the transmitter
//   tx_start  one-cycle start strobe to the transmitter
//   tx_data   byte to the transmitter, stable from SEND until the next load
//   tx_busy   transmitter busy (only consulted when idle)
//   tx_end    one-cycle transmit-complete pulse
module uart_tx_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_end
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            last_flag_q, last_flag_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [7:0]      req_bytes [N_REQ];
  logic [GW-1:0]   pick, hi_pick, lo_pick;
  logic            hi_found;
  logic            rel;

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  // Round-robin pick: the lowest requester above rr_ptr wins; otherwise wrap to the
  // lowest requester at or below rr_ptr. Descending scan leaves the lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (GW'(i) > rr_ptr_q) begin
          hi_found = 1'b1;
          hi_pick  = GW'(i);
        end else begin
          lo_pick  = GW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  assign rel = last_flag_q || (burst_cnt_q == BW'(MAX_BURST)) || !req[g_q];

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    last_flag_d = last_flag_q;
    tx_data_d   = tx_data_q;
    case (state_q)
      StIdle: begin
        if ((|req) && !tx_busy) begin
          g_d         = pick;
          tx_data_d   = req_bytes[pick];
          burst_cnt_d = '0;
          state_d     = StSend;
        end
      end
      StSend: begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        last_flag_d = req_last[g_q];
        state_d     = StWait;
      end
      StWait: begin
        if (tx_end) begin
          if (rel) begin
            // The owner just served becomes lowest priority.
            rr_ptr_d = g_q;
            state_d  = StIdle;
          end else begin
            tx_data_d = req_bytes[g_q];
            state_d   = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      g_q         <= '0;
      rr_ptr_q    <= GW'(N_REQ - 1);
      burst_cnt_q <= '0;
      last_flag_q <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      last_flag_q <= last_flag_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Moore outputs decoded from state and registered owner.
  always_comb begin
    ack   = '0;
    grant = '0;
    if (state_q == StSend) ack[g_q] = 1'b1;
    if (state_q != StIdle) grant[g_q] = 1'b1;
  end

  assign tx_start = (state_q == StSend);
  assign busy     = (state_q != StIdle);
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req, req_last, ack, grant;
  logic [31:0] req_data;
  logic        busy, tx_start, tx_busy;
  logic        tx_end = 1'b0;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arb #(
    .N_REQ     (4),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_end   (tx_end)
  );

  always #5 clk = ~clk;

  // Requester model: each requester presents a queue of bytes and advances on its ack.
  logic [7:0] q_data [4][16];
  logic       q_last [4][16];
  int         q_len  [4];
  int         q_base [4];
  int         ack_cnt [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      q_len[i]  = 0;
      q_base[i] = 0;
      ack_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
  end

  always_comb begin
    int idx;
    idx      = 0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ack_cnt[i] - q_base[i];
      if (idx >= 0 && idx < q_len[i] && idx < 16) begin
        req[i]              = 1'b1;
        req_data[8*i +: 8]  = q_data[i][idx];
        req_last[i]         = q_last[i][idx];
      end
    end
  end

  // Transmitter model: tx_end 10 cycles after each tx_start.
  int   u_cnt = 0;
  logic u_busy = 1'b0;
  logic force_busy = 1'b0;
  assign tx_busy = u_busy | force_busy;

  always @(posedge clk) begin
    tx_end <= 1'b0;
    if (tx_start) begin
      u_busy <= 1'b1;
      u_cnt  <= 10;
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        tx_end <= 1'b1;
        u_busy <= 1'b0;
      end
    end
  end

  // Start-strobe log: byte, owner, and whether an idle cycle preceded it.
  logic [7:0] log_data  [64];
  logic [3:0] log_grant [64];
  logic       log_gap   [64];
  int         log_n = 0;
  logic       saw_idle = 1'b1;

  always @(negedge clk) begin
    if (tx_start && log_n < 64) begin
      log_data[log_n]  <= tx_data;
      log_grant[log_n] <= grant;
      log_gap[log_n]   <= saw_idle;
      log_n            <= log_n + 1;
      saw_idle         <= 1'b0;
    end else if (!busy) begin
      saw_idle <= 1'b1;
    end
  end

  task automatic set_byte(input int r, input int j, input logic [7:0] d, input logic l);
    q_data[r][j] = d;
    q_last[r][j] = l;
  endtask

  task automatic set_len(input int r, input int n);
    q_base[r] = ack_cnt[r];
    q_len[r]  = n;
  endtask

  task automatic do_reset;
    @(negedge clk);
    force_busy = 1'b0;
    for (int i = 0; i < 4; i++) q_len[i] = 0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy && req == 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (tx_start !== 1'b0 || ack !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: tx_start %b ack %b expected 0 0000", tx_start, ack);
    end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_packet;
    int  base, a0, gerr;
    bit  ok;
    logic [7:0] exp_d [3];
    exp_d = '{8'h41, 8'h42, 8'h43};
    base = log_n; a0 = ack_cnt[0]; gerr = 0; ok = 1'b0;
    set_byte(0, 0, 8'h41, 1'b0);
    set_byte(0, 1, 8'h42, 1'b0);
    set_byte(0, 2, 8'h43, 1'b1);
    set_len(0, 3);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy && grant !== 4'b0001) gerr++;
      if (c > 0 && !busy && req == 4'b0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL single_done: timeout got %b expected 1", ok); end
    n_checks++;
    if (log_n - base != 3) begin n_fail++; $display("FAIL single_starts: got %0d expected 3", log_n - base); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (log_data[base+k] !== exp_d[k]) begin
        n_fail++; $display("FAIL single_data%0d: got %h expected %h", k, log_data[base+k], exp_d[k]);
      end
    end
    n_checks++;
    if (ack_cnt[0] - a0 != 3) begin n_fail++; $display("FAIL single_acks: got %0d expected 3", ack_cnt[0] - a0); end
    n_checks++;
    if (gerr != 0) begin n_fail++; $display("FAIL single_grant: got %0d bad cycles expected 0", gerr); end
    n_checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end_idle: grant %b busy %b expected 0000 0", grant, busy);
    end
  endtask

  task automatic test_round_robin;
    int  base;
    bit  ok;
    logic [7:0] exp_d [5];
    logic [3:0] exp_g [5];
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    base = log_n;
    set_byte(0, 0, 8'h10, 1'b1);
    set_byte(0, 1, 8'h14, 1'b1);
    set_byte(1, 0, 8'h11, 1'b1);
    set_byte(2, 0, 8'h12, 1'b1);
    set_byte(3, 0, 8'h13, 1'b1);
    set_len(0, 2); set_len(1, 1); set_len(2, 1); set_len(3, 1);
    wait_idle(500, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_done: timeout got %b expected 1", ok); end
    n_checks++;
    if (log_n - base != 5) begin n_fail++; $display("FAIL rr_starts: got %0d expected 5", log_n - base); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (log_data[base+k] !== exp_d[k] || log_grant[base+k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_order%0d: got %h/%b expected %h/%b", k, log_data[base+k],
                 log_grant[base+k], exp_d[k], exp_g[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (log_gap[base+k] !== 1'b1) begin
          n_fail++; $display("FAIL rr_gap%0d: got %b expected 1", k, log_gap[base+k]);
        end
      end
    end
  endtask

  task automatic test_burst_cap;
    int  base;
    bit  ok;
    logic [7:0] exp_d [7];
    logic [3:0] exp_g [7];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hA4, 8'hA5};
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
    do_reset();
    base = log_n;
    for (int j = 0; j < 6; j++) set_byte(1, j, 8'hA0 + 8'(j), (j == 5));
    set_byte(3, 0, 8'hB0, 1'b1);
    set_len(1, 6); set_len(3, 1);
    wait_idle(600, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_done: timeout got %b expected 1", ok); end
    n_checks++;
    if (log_n - base != 7) begin n_fail++; $display("FAIL burst_starts: got %0d expected 7", log_n - base); end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (log_data[base+k] !== exp_d[k] || log_grant[base+k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL burst_order%0d: got %h/%b expected %h/%b", k, log_data[base+k],
                 log_grant[base+k], exp_d[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_busy_holdoff;
    int herr;
    bit ok;
    herr = 0;
    @(negedge clk);
    force_busy = 1'b1;
    set_byte(2, 0, 8'h5C, 1'b1);
    set_len(2, 1);
    repeat (20) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || grant !== 4'b0) herr++;
    end
    n_checks++;
    if (herr != 0) begin n_fail++; $display("FAIL holdoff_quiet: got %0d active cycles expected 0", herr); end
    force_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h5C || grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL holdoff_start: tx_start %b data %h grant %b expected 1 5c 0100",
               tx_start, tx_data, grant);
    end
    wait_idle(100, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL holdoff_done: timeout got %b expected 1", ok); end
  endtask

  task automatic test_req_drop;
    int  base;
    bit  ok;
    logic [7:0] exp_d [3];
    logic [3:0] exp_g [3];
    exp_d = '{8'h30, 8'h31, 8'h77};
    exp_g = '{4'b0001, 4'b0001, 4'b0010};
    do_reset();
    base = log_n;
    set_byte(0, 0, 8'h30, 1'b0);
    set_byte(0, 1, 8'h31, 1'b0);
    set_byte(1, 0, 8'h77, 1'b1);
    set_len(0, 2); set_len(1, 1);
    wait_idle(300, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL drop_done: timeout got %b expected 1", ok); end
    n_checks++;
    if (log_n - base != 3) begin n_fail++; $display("FAIL drop_starts: got %0d expected 3", log_n - base); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (log_data[base+k] !== exp_d[k] || log_grant[base+k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL drop_order%0d: got %h/%b expected %h/%b", k, log_data[base+k],
                 log_grant[base+k], exp_d[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int a0;
    bit found;
    do_reset();
    a0 = ack_cnt[0];
    found = 1'b0;
    for (int j = 0; j < 8; j++) set_byte(0, j, 8'hC0 + 8'(j), 1'b0);
    set_len(0, 8);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ack_cnt[0] - a0 >= 1 && grant === 4'b0001 && tx_start === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL mid_wait_reached: got %b expected 1", found); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ack %b grant %b busy %b start %b data %h expected 0s",
               ack, grant, busy, tx_start, tx_data);
    end
    set_byte(2, 0, 8'hD2, 1'b1);
    set_len(2, 1);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (found !== 1'b1 || grant !== 4'b0001 || tx_data !== 8'hC1) begin
      n_fail++;
      $display("FAIL mid_regrant: start %b grant %b data %h expected 1 0001 c1", found, grant, tx_data);
    end
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_burst_cap();
    test_busy_holdoff();
    test_req_drop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte-stream requesters, for example per-thread console channels or a DMA log engine.
- Sits between the requesters and the uart_tx start/data/busy/end interface.
- Grants one requester at a time and holds the grant for a packet. A packet ends on its last byte, when the requester drops its request, or when a burst cap is reached.
- Sequences one tx_start per byte and waits for tx_end before issuing the next byte.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes sent per grant before forced rotation (1..255).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-low.
- req  input  N_REQ  per-requester byte-valid/request.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  byte on req_data[i] is the last byte of its packet.
- ack  output  N_REQ  one-cycle pulse: byte of requester i is committed to the transmitter.
- grant  output  N_REQ  one-hot current owner; all zero when idle.
- busy  output  1  arbiter owns the transmitter (state != IDLE).
- tx_start  output  1  one-cycle start strobe to uart_tx.
- tx_data  output  8  byte to uart_tx; held stable from SEND until the next load.
- tx_busy  input  1  transmitter busy.
- tx_end  input  1  one-cycle transmit-complete pulse.

Behaviour:
- Reset (asynchronous, while reset==0):
  - state=IDLE; ack, grant, busy, tx_start = 0; tx_data=8'h00.
  - burst_cnt=0; last_flag=0.
  - rr_ptr=N_REQ-1, so requester 0 has highest priority after reset.
  - Outputs drop immediately, even mid-frame.
- FSM states are IDLE, SEND and WAIT. tx_start, ack and grant are Moore outputs decoded from state and the registered owner g.
- IDLE:
  - If (|req) and tx_busy==0: pick = first i with req[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Load g<=pick, tx_data<=req_data[pick], burst_cnt<=0, then go to SEND.
  - Otherwise stay in IDLE. A held-off request does nothing while tx_busy==1.
- SEND (exactly 1 cycle):
  - tx_start=1; ack[g]=1; grant[g]=1.
  - burst_cnt<=burst_cnt+1; last_flag<=req_last[g] (sampled this cycle). Go to WAIT.
  - The byte is committed even if req[g] falls during SEND.
- WAIT:
  - grant[g]=1; hold until tx_end==1. tx_busy is ignored in this state.
  - On tx_end, release if last_flag==1, OR burst_cnt==MAX_BURST, OR req[g]==0.
  - Release: rr_ptr<=g, go to IDLE. There is at least one IDLE cycle between owners.
  - Continue (no release condition): tx_data<=req_data[g], go to SEND.
- Requester contract:
  - After ack[i], present the next byte (or deassert req[i]) before the next tx_end.
  - req_data[i] must be stable while req[i]=1 until ack[i].
- Latency:
  - req sampled in IDLE at edge k: SEND (tx_start and ack high) during cycle k to k+1.
  - tx_end sampled at edge m with continuation: next tx_start during cycle m to m+1.
- Boundaries:
  - tx_end in IDLE or SEND is ignored.
  - Requests from non-owners are ignored until release.
  - With MAX_BURST=1, rotation happens after every byte.
  - burst_cnt width is $clog2(MAX_BURST+1); it never wraps because release happens at MAX_BURST.
  - Simultaneous requests are resolved only by rr_ptr. After a release, the owner just served has the lowest priority.

Test Plan:
1. Reset, then req[0]=1 with bytes 0x41, 0x42, 0x43 (req_last on 0x43), uart model tx_end 10 cycles after each tx_start -> three tx_start pulses with tx_data 0x41, 0x42, 0x43; three ack[0] pulses; grant=4'b0001 throughout; then IDLE with grant=0 and busy=0.
2. All four requesters each send one byte with req_last=1 (0x10, 0x11, 0x12, 0x13), then req[0] re-requests -> service order 0, 1, 2, 3, 0; each owner change is preceded by at least one IDLE cycle.
3. MAX_BURST=4: req[1] streams 6 bytes 0xA0..0xA5 without last until the final byte, and req[3] is pending with 0xB0 (last) -> tx_data order A0, A1, A2, A3, B0, A4, A5.
4. tx_busy=1 while req[2]=1 in IDLE for 20 cycles -> no tx_start and grant=0; tx_busy falls -> tx_start the following cycle, tx_data=req_data[2].
5. req[0] packet with no last; req[0] drops after the 2nd ack -> release at the 2nd tx_end, only 2 tx_start pulses; the pending req[1] is granted next.
6. Assert reset in WAIT mid-packet -> ack, grant, busy, tx_start = 0 and tx_data=0x00 immediately. After release with req[0]=1 and req[2]=1 -> requester 0 is granted first.
